// File: rtl/adc_pattern_source_pkg.sv
// Shared encodings for the synthetic ADC pattern source: CSR select codes,
// pattern modes, FSM states and readout field positions.
package adc_pattern_source_pkg;

  localparam logic [1:0] SEL_CTRL  = 2'b00;
  localparam logic [1:0] SEL_TABLE = 2'b01;
  localparam logic [1:0] SEL_RAMP  = 2'b10;
  localparam logic [1:0] SEL_DIV   = 2'b11;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_CONST = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_TABLE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int CTRL_RUN_BIT     = 2;
  localparam int CTRL_ONESHOT_BIT = 3;
  localparam int CTRL_LEN_LSB     = 8;
  localparam int TBL_IDX_LSB      = 26;

  localparam int RO_DONE_BIT = 2;
  localparam int RO_RUN_BIT  = 3;
  localparam int RO_IDX_LSB  = 4;
  localparam int RO_VAL_LSB  = 16;

  function automatic logic [31:0] pack_readout(state_e st, logic [3:0] idx, logic [15:0] val);
    logic [31:0] r;
    r                  = '0;
    r[1:0]             = st;
    r[RO_DONE_BIT]     = (st == ST_DONE);
    r[RO_RUN_BIT]      = (st == ST_RUN);
    r[RO_IDX_LSB +: 4] = idx;
    r[RO_VAL_LSB +: 16] = val;
    return r;
  endfunction

endpackage

// File: rtl/adc_valid_cadence.sv
// Sample-rate divider: one-cycle tick every div+1 enabled cycles. A load
// makes the written divider count from the load cycle itself.
module adc_valid_cadence (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic [15:0] div_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d, eff;

  // Down-counter: zero means "tick now"; a load behaves as if the counter held the new divider.
  always_comb begin
    eff    = load_i ? load_val_i : cnt_q;
    tick_o = en_i && !clr_i && (eff == 16'd0);
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i || load_i) begin
      if (eff == 16'd0) cnt_d = load_i ? load_val_i : div_i;
      else              cnt_d = eff - 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/adc_pattern_source.sv
// Synthetic ADC front end: CSR-programmed constant/ramp/table patterns emitted
// as registered I/Q sample strobes at a programmable cadence.
module adc_pattern_source
  import adc_pattern_source_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int TABLE_DEPTH = 16,
  parameter int CH_OFFSET   = 0
) (
  input  logic                  adcClk,
  input  logic                  adcReset,
  input  logic                  csrStrobe,
  input  logic [31:0]           GPIO_OUT,
  output logic [31:0]           readout,
  output logic                  adcValidOut,
  output logic [DATA_WIDTH-1:0] adc0Out,
  output logic [DATA_WIDTH-1:0] adc1Out,
  output logic [DATA_WIDTH-1:0] adc2Out,
  output logic [DATA_WIDTH-1:0] adc3Out,
  output logic [DATA_WIDTH-1:0] adc0QOut,
  output logic [DATA_WIDTH-1:0] adc1QOut,
  output logic [DATA_WIDTH-1:0] adc2QOut,
  output logic [DATA_WIDTH-1:0] adc3QOut
);

  localparam int IDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
  typedef logic [DATA_WIDTH-1:0] smp_t;

  function automatic smp_t chan_val(smp_t v, int k);
    return v + smp_t'(k * CH_OFFSET);
  endfunction

  function automatic smp_t neg_val(smp_t v);
    smp_t z;
    z = '0;
    return z - v;
  endfunction

  logic [1:0]  sel;
  logic        ctrl_wr, tbl_wr, ramp_wr, div_wr;
  mode_e       wr_mode;
  logic        start, running, tick, valid_d, last_entry, finish, keep_run;
  logic        unused_gpio;

  state_e      state_q;
  mode_e       mode_q;
  logic        one_shot_q;
  logic [3:0]  last_idx_q, idx_q;
  smp_t        acc_q, inc_q, v_q, sample;
  logic [15:0] div_q;
  logic        valid_q;
  smp_t        tbl_q [TABLE_DEPTH];
  smp_t        i_q [4];
  smp_t        q_q [4];

  assign sel         = GPIO_OUT[31:30];
  assign ctrl_wr     = csrStrobe && (sel == SEL_CTRL);
  assign tbl_wr      = csrStrobe && (sel == SEL_TABLE);
  assign ramp_wr     = csrStrobe && (sel == SEL_RAMP);
  assign div_wr      = csrStrobe && (sel == SEL_DIV);
  assign wr_mode     = mode_e'(GPIO_OUT[1:0]);
  assign unused_gpio = ^GPIO_OUT[25:16];

  assign start      = ctrl_wr && GPIO_OUT[CTRL_RUN_BIT] && (wr_mode != MODE_OFF);
  assign running    = (state_q == ST_RUN);
  // Any CTRL write in the tick cycle (stop or restart) swallows that sample.
  assign valid_d    = tick && !ctrl_wr;
  assign last_entry = (idx_q == last_idx_q);
  assign finish     = valid_d && (mode_q == MODE_TABLE) && one_shot_q && last_entry;
  assign keep_run   = start || (running && !ctrl_wr && !finish);

  adc_valid_cadence u_cadence (
    .clk_i      (adcClk),
    .rst_i      (adcReset),
    .en_i       (running),
    .clr_i      (start),
    .load_i     (div_wr),
    .load_val_i (GPIO_OUT[15:0]),
    .div_i      (div_q),
    .tick_o     (tick)
  );

  always_comb begin
    sample = '0;
    case (mode_q)
      MODE_CONST: sample = tbl_q[0];
      MODE_RAMP:  sample = acc_q;
      MODE_TABLE: sample = tbl_q[idx_q[IDX_W-1:0]];
      default:    sample = '0;
    endcase
  end

  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_OFF;
      one_shot_q <= 1'b0;
      last_idx_q <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      inc_q      <= '0;
      div_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (ctrl_wr) begin
        mode_q     <= wr_mode;
        one_shot_q <= GPIO_OUT[CTRL_ONESHOT_BIT];
        last_idx_q <= GPIO_OUT[CTRL_LEN_LSB +: 4];
      end
      if (ramp_wr) inc_q <= GPIO_OUT[DATA_WIDTH-1:0];
      if (div_wr)  div_q <= GPIO_OUT[15:0];

      case (state_q)
        ST_RUN: begin
          if (ctrl_wr)     state_q <= start ? ST_RUN : ST_IDLE;
          else if (finish) state_q <= ST_DONE;
        end
        default: begin
          if (ctrl_wr) state_q <= start ? ST_RUN : ST_IDLE;
        end
      endcase

      if (start) begin
        idx_q <= '0;
        acc_q <= '0;
      end else if (valid_d) begin
        if (mode_q == MODE_TABLE) idx_q <= last_entry ? 4'd0 : idx_q + 4'd1;
        if (mode_q == MODE_RAMP)  acc_q <= acc_q + inc_q;
      end
    end
  end

  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) begin
      for (int i = 0; i < TABLE_DEPTH; i++) tbl_q[i] <= '0;
    end else if (tbl_wr) begin
      tbl_q[GPIO_OUT[TBL_IDX_LSB +: IDX_W]] <= GPIO_OUT[DATA_WIDTH-1:0];
    end
  end

  // Sample registers load only with a valid and fall to zero once the run ends.
  always_ff @(posedge adcClk or posedge adcReset) begin
    if (adcReset) begin
      v_q <= '0;
      for (int k = 0; k < 4; k++) begin
        i_q[k] <= '0;
        q_q[k] <= '0;
      end
    end else if (valid_d) begin
      v_q <= sample;
      for (int k = 0; k < 4; k++) begin
        i_q[k] <= chan_val(sample, k);
        q_q[k] <= neg_val(chan_val(sample, k));
      end
    end else if (!keep_run) begin
      v_q <= '0;
      for (int k = 0; k < 4; k++) begin
        i_q[k] <= '0;
        q_q[k] <= '0;
      end
    end
  end

  assign adcValidOut = valid_q;
  assign adc0Out     = i_q[0];
  assign adc1Out     = i_q[1];
  assign adc2Out     = i_q[2];
  assign adc3Out     = i_q[3];
  assign adc0QOut    = q_q[0];
  assign adc1QOut    = q_q[1];
  assign adc2QOut    = q_q[2];
  assign adc3QOut    = q_q[3];
  assign readout     = pack_readout(state_q, idx_q, 16'(v_q));

endmodule
